clk_div_sequencer: RTL and testbench
====================================

// Module: clk_div_sequencer
// PURPOSE
//  Runtime controller for a programmable 50%-duty clock divider. Accepts divide-ratio
//  updates over a valid/ready handshake and applies them only at a period boundary.
//  Output is glitch-free. Provides a divided clock plus a one-cycle period tick.
//  Sits between the colour-mixer control logic and the PWM/refresh timing consumers.
// PARAMETERS
//  DIV_W        8   width of ratio field; legal ratio 2..2^DIV_W-1
//  DEFAULT_DIV  3   active ratio after reset
// PORTS
//  clk_in      in   1      source clock; all state on posedge except the half-cycle flop
//  rst         in   1      synchronous, active-high reset
//  en          in   1      run request; low = stop cleanly at the next boundary
//  cfg_valid   in   1      new ratio offered
//  cfg_div     in   DIV_W  requested ratio N
//  cfg_ready   out  1      high when no update is pending
//  cfg_err     out  1      one-cycle pulse: accepted ratio <2, ignored
//  active_div  out  DIV_W  ratio currently in force
//  clk_out     out  1      divided clock, 50% duty for even and odd N
//  tick_out    out  1      one clk_in pulse on the first cycle of each period
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=STOP, cnt=0, active_div=DEFAULT_DIV, pending cleared.
//   - cfg_ready=1, cfg_err=0, tick_out=0, clk_out=0.
//   - Negedge flop cleared on any negedge while rst=1.
//   - Mid-operation reset aborts the period and drops any pending update.
//  States: STOP, RUN, RUN_PEND.
//   - STOP: cnt held 0; clk_out=0; tick_out=0.
//     - Accepted cfg writes active_div on the next cycle (no pending).
//     - en=1 -> RUN; the next cycle is cnt=0 with tick_out=1.
//   - RUN: cnt counts 0..N-1 and wraps; tick_out=1 when cnt==0.
//     - Handshake cfg_valid&cfg_ready with cfg_div>=2 -> store pending, go to RUN_PEND.
//       cfg_ready drops the following cycle.
//   - RUN_PEND: cfg_ready=0 and cfg_valid is ignored.
//     - At cnt==N-1: active_div<=pending, cnt<=0, -> RUN.
//     - The new ratio governs the first cycle of the new period, including its tick.
//   - en=0 in RUN/RUN_PEND: the current period completes.
//     - At the boundary, any pending update is applied first, then -> STOP.
//     - en re-asserted before the boundary cancels the stop.
//  Waveform (h = N>>1):
//   - p = (cnt < h), registered on posedge.
//   - Odd N: n = p sampled on negedge clk_in; clk_out = p | n, giving h+0.5 cycles high
//     and h+0.5 cycles low.
//   - Even N: clk_out = p, giving h cycles high and h cycles low.
//   - Odd/even select uses active_div[0], which changes only at a boundary, so no glitch.
//  Errors: cfg_div<2 while cfg_ready=1 is still handshaken.
//   - cfg_err pulses for 1 cycle; state and active_div unchanged.
//  Same-cycle events:
//   - cfg handshake on a boundary cycle in RUN goes to pending and applies next boundary.
//   - rst dominates en and cfg.
//  Width: cnt is DIV_W bits, compared against active_div-1. No overflow for N<=2^DIV_W-1.
// STRUCTURE
//  Package clk_div_pkg:
//   - localparam MIN_DIV=2.
//   - typedef enum {STOP,RUN,RUN_PEND} seq_state_t.
//   - default DIV_W.
//  Sub-module half_cycle_stretch (p, clk_in, rst, odd -> clk_out):
//   - negedge flop plus OR/select.
//   - The only negedge logic in the block.
//  Top: FSM, counter, pending register, tick and handshake logic.
// TESTING
//  1. Reset, en=1, N=3 -> clk_out high 1.5 / low 1.5 cycles; tick_out every 3 cycles.
//  2. Running N=4, write 6 mid-period -> cfg_ready=0 until boundary.
//     The 4-period completes intact; next periods are 3 high / 3 low; active_div=6 at tick.
//  3. Write cfg_div=1 and cfg_div=0 -> cfg_err pulses 1 cycle each; active_div unchanged.
//  4. en=0 at cnt=1 of N=5 -> finishes cnt 4, then clk_out=0 and tick_out=0.
//     en=1 -> tick_out on the first cycle.
//  5. Pending write 7 plus rst mid-period -> next cycle active_div=3, cfg_ready=1, clk_out=0.
//  6. Boundary-cycle handshake (cnt==N-1) -> new ratio takes effect one full period later.
//     Check clk_out is glitch-free across the odd-to-even switch (3->4).

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider sequencer.
// Holds the FSM state encoding, the minimum legal ratio and the default width.
package clk_div_pkg;

   localparam int DIV_W_DEF = 8;
   localparam int MIN_DIV   = 2;

   typedef enum logic [1:0] {
      STOP     = 2'd0,
      RUN      = 2'd1,
      RUN_PEND = 2'd2
   } seq_state_t;

endpackage

// File: rtl/clk_div_sequencer_stretch.sv
// Half-cycle stretcher: extends the high phase by half a source cycle for odd N.
// This is the only logic in the divider clocked on the falling edge.
module half_cycle_stretch (
   input  logic clk_in,
   input  logic rst,
   input  logic p,
   input  logic odd,
   input  logic run,
   output logic clk_out
);

   logic n;

   // Delay the phase bit by half a source cycle
   always_ff @(negedge clk_in) begin
      if (rst) n <= 1'b0;
      else     n <= p;
   end

   // The stretch term only ever extends a high phase while the divider runs
   assign clk_out = p | (odd & run & n);

endmodule

// File: rtl/clk_div_sequencer.sv
// Runtime controller for a programmable 50%-duty clock divider.
// Ratio updates are handshaken and take effect only at a period boundary.
module clk_div_sequencer
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [DIV_W-1:0] active_div,
   output logic             clk_out,
   output logic             tick_out
);

   seq_state_t       state;
   seq_state_t       state_nx;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nx;
   logic [DIV_W-1:0] div_nx;
   logic [DIV_W-1:0] pend;
   logic [DIV_W-1:0] pend_nx;
   logic             p;
   logic             p_nx;
   logic             run_q;
   logic             hs;
   logic             good;
   logic             bnd;

   assign hs   = cfg_valid & cfg_ready;
   assign good = hs & (cfg_div >= DIV_W'(MIN_DIV));
   assign bnd  = (cnt == (active_div - DIV_W'(1)));
   assign p_nx = (state_nx != STOP) && (cnt_nx < (div_nx >> 1));

   // State register
   always_ff @(posedge clk_in) begin
      if (rst) state <= STOP;
      else     state <= state_nx;
   end

   // Next state, counter, ratio and pending-update selection
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      div_nx   = active_div;
      pend_nx  = pend;
      unique case (state)
         STOP: begin
            cnt_nx = '0;
            if (good) div_nx = cfg_div;
            if (en) state_nx = RUN;
         end
         RUN: begin
            if (bnd) begin
               cnt_nx = '0;
               if (!en) begin
                  state_nx = STOP;
                  if (good) div_nx = cfg_div;
               end else if (good) begin
                  pend_nx  = cfg_div;
                  state_nx = RUN_PEND;
               end
            end else begin
               cnt_nx = cnt + DIV_W'(1);
               if (good) begin
                  pend_nx  = cfg_div;
                  state_nx = RUN_PEND;
               end
            end
         end
         RUN_PEND: begin
            if (bnd) begin
               cnt_nx   = '0;
               div_nx   = pend;
               state_nx = en ? RUN : STOP;
            end else begin
               cnt_nx = cnt + DIV_W'(1);
            end
         end
         default: state_nx = STOP;
      endcase
   end

   // Datapath registers: counter, ratio, pending ratio, phase and error pulse
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt        <= '0;
         active_div <= DIV_W'(DEFAULT_DIV);
         pend       <= '0;
         p          <= 1'b0;
         run_q      <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         cnt        <= cnt_nx;
         active_div <= div_nx;
         pend       <= pend_nx;
         p          <= p_nx;
         run_q      <= (state_nx != STOP);
         cfg_err    <= hs & ~good;
      end
   end

   // Handshake and period tick outputs
   always_comb begin
      cfg_ready = (state != RUN_PEND);
      tick_out  = (state != STOP) && (cnt == '0);
   end

   half_cycle_stretch u_stretch (
      .clk_in  (clk_in),
      .rst     (rst),
      .p       (p),
      .odd     (active_div[0]),
      .run     (run_q),
      .clk_out (clk_out)
   );

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Self-checking bench for clk_div_sequencer: directed scenarios plus random traffic.
// Expected waveform: within a period of N cycles, high for the first N half-cycles.
module tb_clk_div_sequencer;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_div = 8'd0;
   logic       cfg_ready;
   logic       cfg_err;
   logic [7:0] active_div;
   logic       clk_out;
   logic       tick_out;

   int n_tests = 0;
   int n_fail  = 0;

   bit m_run = 0;
   int m_pos = 0;
   int m_div = 3;
   int m_pend = 0;
   bit m_pv = 0;
   bit m_err = 0;
   bit en_v = 0;

   clk_div_sequencer #(.DIV_W(8), .DEFAULT_DIV(3)) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_div    (cfg_div),
      .cfg_ready  (cfg_ready),
      .cfg_err    (cfg_err),
      .active_div (active_div),
      .clk_out    (clk_out),
      .tick_out   (tick_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Period-level reference: position in period, ratio in force, one pending slot.
   task automatic model(bit r, bit e, bit v, int d);
      bit acc;
      bit ok;
      if (r) begin
         m_run = 0; m_pos = 0; m_div = 3; m_pv = 0; m_err = 0;
         return;
      end
      acc = v && !m_pv;
      ok  = acc && (d >= 2);
      m_err = acc && !ok;
      if (!m_run) begin
         if (ok) m_div = d;
         if (e) begin m_run = 1; m_pos = 0; end
      end else if (m_pos == m_div - 1) begin
         m_pos = 0;
         if (m_pv) begin m_div = m_pend; m_pv = 0; end
         if (ok) begin
            if (e) begin m_pend = d; m_pv = 1; end
            else m_div = d;
         end
         if (!e) m_run = 0;
      end else begin
         m_pos++;
         if (ok) begin m_pend = d; m_pv = 1; end
      end
   endtask

   task automatic step(bit r, bit e, bit v, int d);
      rst = r; en = e; cfg_valid = v; cfg_div = 8'(d);
      @(posedge clk_in);
      model(r, e, v, d);
      #1;
      chk("tick", tick_out, m_run && m_pos == 0);
      chk("ready", cfg_ready, !m_pv);
      chk("err", cfg_err, m_err);
      chk("div", active_div, m_div);
      chk("clk_first_half", clk_out, m_run && (2 * m_pos < m_div));
      @(negedge clk_in);
      #1;
      chk("clk_second_half", clk_out, m_run && (2 * m_pos + 1 < m_div));
   endtask

   task automatic idle(int k);
      repeat (k) step(0, en_v, 0, 0);
   endtask

   task automatic wait_pos(int k);
      bit found = 0;
      for (int i = 0; i < 64; i++) begin
         if (m_run && m_pos == k) begin found = 1; break; end
         idle(1);
      end
      if (!found) begin
         n_fail++;
         $error("FAIL wait_pos observed=timeout expected=cnt %0d", k);
      end
   endtask

   task automatic wait_div_tick(int nd);
      bit found = 0;
      for (int i = 0; i < 64; i++) begin
         if (m_run && m_pos == 0 && m_div == nd) begin found = 1; break; end
         idle(1);
      end
      if (!found) begin
         n_fail++;
         $error("FAIL wait_div observed=timeout expected=div %0d", nd);
      end else begin
         chk("div_at_tick", active_div, nd);
         chk("tick_at_apply", tick_out, 1);
      end
   endtask

   initial begin
      bit r;
      bit v;
      int d;
      // reset and default ratio 3
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("reset_clk", clk_out, 0);
      en_v = 1;
      idle(10);
      // ratio 4, then 6 written mid-period
      step(0, 1, 1, 4);
      wait_div_tick(4);
      idle(1);
      step(0, 1, 1, 6);
      idle(2);
      wait_div_tick(6);
      idle(13);
      // illegal ratios
      step(0, 1, 1, 1);
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      idle(2);
      // clean stop at cnt 1 of N=5, then restart
      step(0, 1, 1, 5);
      wait_div_tick(5);
      wait_pos(1);
      en_v = 0;
      idle(10);
      en_v = 1;
      idle(6);
      // pending update aborted by reset
      wait_pos(1);
      step(0, 1, 1, 7);
      idle(1);
      step(1, 1, 0, 0);
      chk("rst_abort_div", active_div, 3);
      chk("rst_abort_ready", cfg_ready, 1);
      idle(5);
      // boundary-cycle handshake, odd to even switch
      wait_pos(2);
      step(0, 1, 1, 4);
      idle(14);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 19) == 0) en_v = !en_v;
         v = ($urandom_range(0, 4) == 0);
         d = $urandom_range(0, 9);
         step(r, en_v, v, d);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
